// File: rtl/serial_sub_4.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Ports: clk, rst (async high), start, a, b, bin -> diff, bout, [ovf], busy, done. Optional ovf: SERIAL_SUB_OVF_EN.
module serial_sub_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, nstate;

  logic [WIDTH-1:0] ra, rb, res;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             ai, bi, d, brn, last;
`ifdef SERIAL_SUB_OVF_EN
  logic             am, bm;
`endif

  // one full-subtractor cell on the current LSBs
  always_comb begin
    ai   = ra[0];
    bi   = rb[0];
    d    = ai ^ bi ^ br;
    brn  = (~ai & bi) | (~(ai ^ bi) & br);
    last = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state)
      IDLE: if (start) nstate = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) nstate = DONE;
      end
      DONE: begin
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra   <= '0;
      rb   <= '0;
      res  <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      am   <= 1'b0;
      bm   <= 1'b0;
      ovf  <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (start) begin
        ra  <= a;
        rb  <= b;
        br  <= bin;
        cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
        am  <= a[WIDTH-1];
        bm  <= b[WIDTH-1];
`endif
      end
    end else if (state == RUN) begin
      ra  <= ra >> 1;
      rb  <= rb >> 1;
      br  <= brn;
      res <= {d, res[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
      // final bit: publish result alongside the DONE transition
      if (last) begin
        diff <= {d, res[WIDTH-1:1]};
        bout <= brn;
`ifdef SERIAL_SUB_OVF_EN
        ovf  <= (am ^ bm) & (d ^ am);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_4.sv
// Testbench for serial_sub_4 (WIDTH=4), scoreboard-based.
// Define SERIAL_SUB_OVF_EN to also check ovf.
module tb_serial_sub_4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail = 0;

  serial_sub_4 #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .bin(bin),
    .diff(diff),
    .bout(bout),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf),
`endif
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [W-1:0] ma, logic [W-1:0] mb,
                                 logic mbin);
    exp_t m;
    logic [W:0] r;
    r = {1'b0, ma} - {1'b0, mb} - (W+1)'(mbin);
    m.diff = r[W-1:0];
    m.bout = r[W];
    m.ovf  = (ma[W-1] ^ mb[W-1]) & (r[W-1] ^ ma[W-1]);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // count edges after the start edge until done; then compare and
  // confirm the return to idle one edge later
  task automatic wait_done(input string tag);
    int   n;
    bit   seen;
    exp_t e;
    seen = 1'b0;
    n = 0;
    while (!seen && n < W + 4) begin
      @(posedge clk);
      #1;
      n++;
      if (done) seen = 1'b1;
      else chk({tag, "_busy"}, 32'(busy), 32'(1));
    end
    chk({tag, "_latency"}, 32'(n), 32'(W));
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_diff"}, 32'(diff), 32'(e.diff));
      chk({tag, "_bout"}, 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
      chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
      chk({tag, "_busy_done"}, 32'(busy), 32'(0));
    end else if (sb.size() > 0) begin
      void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
    chk({tag, "_idle_busy"}, 32'(busy), 32'(0));
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ta,
                       input logic [W-1:0] tb, input logic tbin);
    @(negedge clk);
    a = ta;
    b = tb;
    bin = tbin;
    start = 1'b1;
    sb.push_back(model(ta, tb, tbin));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 32'(1));
    wait_done(tag);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_diff", 32'(diff), 32'(0));
    chk("rst_bout", 32'(bout), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'(0));
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_op("op9m3", 4'd9, 4'd3, 1'b0);
    do_op("op3m9", 4'd3, 4'd9, 1'b0);
    do_op("op0m0b", 4'd0, 4'd0, 1'b1);
    do_op("op8m1", 4'd8, 4'd1, 1'b0);
    do_op("op5m2", 4'd5, 4'd2, 1'b0);

    // start held high, operands disturbed mid-run
    @(negedge clk);
    a = 4'd9;
    b = 4'd3;
    bin = 1'b0;
    start = 1'b1;
    sb.push_back(model(4'd9, 4'd3, 1'b0));
    @(posedge clk);
    #1;
    a = 4'd1;
    b = 4'd15;
    wait_done("held");
    sb.push_back(model(4'd1, 4'd15, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("held_reaccept", 32'(busy), 32'(1));
    chk("held_diff_hold", 32'(diff), 32'(6));
    wait_done("held2");

    // reset in the second RUN cycle
    @(negedge clk);
    a = 4'd5;
    b = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_diff", 32'(diff), 32'(0));
    chk("abort_bout", 32'(bout), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
    chk("abort_ovf", 32'(ovf), 32'(0));
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done), 32'(0));
    end
    do_op("post_rst", 4'd12, 4'd5, 1'b1);

    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++)
          do_op("sweep", 4'(i), 4'(j), 1'(k));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/serial_sub_4.md
SERIAL_SUB_4 -- requirements
Module: serial_sub_4

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request to begin a subtraction, sampled on rising clk.
REQ-005 SHALL have port: a  input  WIDTH  minuend, captured when start is accepted.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, captured when start is accepted.
REQ-007 SHALL have port: bin  input  1  borrow-in, captured when start is accepted.
REQ-008 SHALL have port: diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-009 SHALL have port: bout  output  1  borrow-out; 1 iff a < b + bin, unsigned.
REQ-010 SHALL have port: busy  output  1  high while a subtraction is in progress.
REQ-011 SHALL have port: done  output  1  single-cycle pulse marking a new valid diff/bout.

Function
REQ-012 SHALL implement FSM with states IDLE, RUN, DONE.
REQ-013 SHALL, in IDLE with start=1 at a rising edge, capture a, b and bin, clear the bit counter, and enter RUN.
REQ-014 SHALL, in RUN, process exactly one bit per cycle, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); br is initialised to the captured bin.
REQ-015 SHALL shift each d into an internal result shift register at the MSB end, so the register holds the full result after WIDTH RUN cycles.
REQ-016 SHALL leave RUN for DONE on the edge that processes bit WIDTH-1, which is the WIDTH-th edge after the start edge.
REQ-017 SHALL, on entry to DONE, load diff from the result register and bout from the final br.
REQ-018 SHALL assert done only in DONE, for exactly one cycle, then return to IDLE on the next edge.
REQ-019 SHALL assert busy in RUN only; busy=0 in IDLE and DONE.
REQ-020 SHALL hold diff and bout stable from DONE until the next DONE, including throughout a following RUN.
REQ-021 SHALL ignore start while in RUN or DONE; captured operands are not disturbed and no request is queued.
REQ-022 SHALL ignore changes on a, b and bin outside the capture edge.
REQ-023 SHALL accept back-to-back starts, giving at most one accepted start per WIDTH+2 cycles (start edge, WIDTH RUN edges, DONE edge).

Reset
REQ-024 SHALL, while rst=1, immediately and asynchronously force state=IDLE, diff=0, bout=0, busy=0, done=0, ovf=0, and clear all internal registers.
REQ-025 SHALL abort any RUN in progress on reset, with no done pulse afterward; the first start after rst deasserts is accepted normally.

Configuration
REQ-026 SHALL, when macro SERIAL_SUB_OVF_EN is defined, add port ovf  output  1  signed two's-complement overflow, loaded in DONE with diff as (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]) using the captured operands, and held with diff.
REQ-027 SHALL, when SERIAL_SUB_OVF_EN is undefined, have no ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover: WIDTH=4, a=9, b=3, bin=0, start pulse -> busy for 4 cycles, then done pulse with diff=6, bout=0.
REQ-029 SHALL cover: a=3, b=9, bin=0 -> diff=0xA, bout=1; then a=0, b=0, bin=1 -> diff=0xF, bout=1.
REQ-030 SHALL cover: start held high continuously with operands changed mid-RUN -> result reflects the captured operands only; next acceptance occurs in IDLE after done.
REQ-031 SHALL cover: rst asserted during the 2nd RUN cycle -> all outputs 0 immediately, no done; a new start then yields a correct result.
REQ-032 SHALL cover, with SERIAL_SUB_OVF_EN: a=8, b=1, bin=0 -> diff=7, bout=0, ovf=1; a=5, b=2 -> diff=3, ovf=0.
REQ-033 SHALL cover: exhaustive a, b, bin sweep at WIDTH=4 against a reference model a - b - bin, with done after exactly WIDTH+1 edges from the start edge.
